// File: rtl/router_fsm_nch_if.sv
// Router FSM bus: source/FIFO status inputs and load-control outputs.
// master drives the status side, slave is the FSM that decodes it.
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;
    logic [NUM_CH-1:0] dest_sel;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_err;
    logic              timeout_err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        output parity_done, low_packet_valid,
        input  dest_sel, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, write_enb_reg, rst_int_reg, busy,
        input  drop_err, timeout_err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        input  parity_done, low_packet_valid,
        output dest_sel, detect_add, lfd_state, ld_state, laf_state,
        output full_state, write_enb_reg, rst_int_reg, busy,
        output drop_err, timeout_err
    );
endinterface

// File: rtl/router_fsm_nch.sv
// Control FSM for a 1xNUM_CH packet router: header decode, load sequencing,
// full stalls, invalid-address drop and wait-for-empty timeout drop.
// Ports: clock, reset (async high), bus (router_fsm_nch_if.slave).
module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 0,
    parameter int TO_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    router_fsm_nch_if.slave  bus
);
    typedef enum logic [3:0] {
        S_DECODE, S_LFD, S_LD, S_WAIT, S_LP,
        S_CPE, S_FULL, S_LAF, S_DROP
    } state_t;

    localparam bit TO_EN = (WAIT_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TO_EN ? WAIT_TIMEOUT - 1 : 0);

    state_t            ps_q, ps_d;
    logic [NUM_CH-1:0] dest_q, dest_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              drop_err_q, drop_err_d;
    logic              to_err_q, to_err_d;

    // Destination is held one-hot; an address >= NUM_CH shifts out to zero.
    logic [NUM_CH-1:0] addr_oh;
    logic              addr_ok;
    logic              addr_empty;
    logic              sel_empty;
    logic              sel_soft;

    assign addr_oh    = NUM_CH'(1) << bus.data_in;
    assign addr_ok    = |addr_oh;
    assign addr_empty = |(bus.fifo_empty & addr_oh);
    assign sel_empty  = |(bus.fifo_empty & dest_q);
    assign sel_soft   = |(bus.soft_reset & dest_q);

    always_comb begin
        ps_d       = ps_q;
        dest_d     = dest_q;
        cnt_d      = '0;
        drop_err_d = 1'b0;
        to_err_d   = 1'b0;
        case (ps_q)
            S_DECODE: begin
                if (bus.pkt_valid) begin
                    if (!addr_ok) begin
                        ps_d       = S_DROP;
                        drop_err_d = 1'b1;
                    end else begin
                        dest_d = addr_oh;
                        ps_d   = addr_empty ? S_LFD : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_empty) begin
                    ps_d = S_LFD;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    ps_d     = S_DROP;
                    to_err_d = 1'b1;
                end
            end
            S_LFD: ps_d = S_LD;
            S_LD: begin
                if (bus.fifo_full)       ps_d = S_FULL;
                else if (!bus.pkt_valid) ps_d = S_LP;
            end
            S_FULL: begin
                if (!bus.fifo_full) ps_d = S_LAF;
            end
            S_LAF: begin
                if (bus.parity_done)           ps_d = S_DECODE;
                else if (bus.low_packet_valid) ps_d = S_LP;
                else                           ps_d = S_LD;
            end
            S_LP:  ps_d = S_CPE;
            S_CPE: ps_d = bus.fifo_full ? S_FULL : S_DECODE;
            S_DROP: begin
                if (!bus.pkt_valid) ps_d = S_DECODE;
            end
            default: ps_d = S_DECODE;
        endcase
        // Output-side soft reset of the selected channel aborts the packet.
        if (ps_q != S_DECODE && ps_q != S_DROP && sel_soft) begin
            ps_d     = S_DECODE;
            to_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_q       <= S_DECODE;
            dest_q     <= '0;
            cnt_q      <= '0;
            drop_err_q <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            dest_q     <= dest_d;
            cnt_q      <= cnt_d;
            drop_err_q <= drop_err_d;
            to_err_q   <= to_err_d;
        end
    end

    assign bus.detect_add    = (ps_q == S_DECODE);
    assign bus.lfd_state     = (ps_q == S_LFD);
    assign bus.ld_state      = (ps_q == S_LD);
    assign bus.laf_state     = (ps_q == S_LAF);
    assign bus.full_state    = (ps_q == S_FULL);
    assign bus.rst_int_reg   = (ps_q == S_CPE);
    assign bus.write_enb_reg = (ps_q == S_LD) || (ps_q == S_LP) ||
                               (ps_q == S_LAF);
    assign bus.busy          = (ps_q == S_LFD) || (ps_q == S_WAIT) ||
                               (ps_q == S_LP) || (ps_q == S_CPE) ||
                               (ps_q == S_FULL) || (ps_q == S_LAF);
    assign bus.dest_sel      = (ps_q == S_DECODE || ps_q == S_DROP) ?
                               '0 : dest_q;
    assign bus.drop_err      = drop_err_q;
    assign bus.timeout_err   = to_err_q;
endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, WAIT_TIMEOUT=8).
// State is observed as {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}.
module tb_router_fsm_nch;
    // Expected output vectors per state.
    localparam logic [7:0] O_DEC  = 8'h80;
    localparam logic [7:0] O_LFD  = 8'h41;
    localparam logic [7:0] O_LD   = 8'h24;
    localparam logic [7:0] O_LAF  = 8'h15;
    localparam logic [7:0] O_FULL = 8'h09;
    localparam logic [7:0] O_LP   = 8'h05;
    localparam logic [7:0] O_CPE  = 8'h03;
    localparam logic [7:0] O_WAIT = 8'h01;
    localparam logic [7:0] O_DROP = 8'h00;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

    router_fsm_nch #(
        .NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(8), .TO_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.write_enb_reg,
                bus.rst_int_reg, bus.busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic st(input string tag, input logic [7:0] exp);
        check(tag, 32'(outs()), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in = 2'd0;
        bus.fifo_full = 1'b0;
        bus.fifo_empty = 3'b111;
        bus.soft_reset = 3'b000;
        bus.parity_done = 1'b0;
        bus.low_packet_valid = 1'b0;
        #3;
        st("rst_state", O_DEC);
        check("rst_dest", 32'(bus.dest_sel), 0);
        check("rst_errs", {30'd0, bus.drop_err, bus.timeout_err}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: normal packet to channel 1, four payload cycles
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd1;
        step(); st("t1_lfd", O_LFD);
        check("t1_dest", 32'(bus.dest_sel), 32'h2);
        for (int i = 0; i < 4; i++) begin
            step(); st("t1_ld", O_LD);
        end
        bus.pkt_valid = 1'b0;
        step(); st("t1_lp", O_LP);
        step(); st("t1_cpe", O_CPE);
        check("t1_cpe_dest", 32'(bus.dest_sel), 32'h2);
        step(); st("t1_dec", O_DEC);
        check("t1_dec_dest", 32'(bus.dest_sel), 0);

        // 2: invalid address 3 dropped, pkt_valid high 5 cycles
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd3;
        step(); st("t2_drop", O_DROP);
        check("t2_drop_err", 32'(bus.drop_err), 1);
        check("t2_dest", 32'(bus.dest_sel), 0);
        for (int i = 0; i < 4; i++) begin
            step(); st("t2_hold", O_DROP);
            check("t2_err_once", 32'(bus.drop_err), 0);
        end
        bus.pkt_valid = 1'b0;
        step(); st("t2_dec", O_DEC);

        // 3a: channel 2 never empties, timeout after 8 WAIT cycles
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd2;
        bus.fifo_empty = 3'b011;
        step(); st("t3_wait1", O_WAIT);
        check("t3_dest", 32'(bus.dest_sel), 32'h4);
        for (int i = 2; i <= 8; i++) begin
            step(); st("t3_wait", O_WAIT);
            check("t3_no_to", 32'(bus.timeout_err), 0);
        end
        step(); st("t3_drop", O_DROP);
        check("t3_to_err", 32'(bus.timeout_err), 1);
        step(); check("t3_to_once", 32'(bus.timeout_err), 0);
        bus.pkt_valid = 1'b0;
        step(); st("t3_dec", O_DEC);

        // 3b: empty rises on the 8th WAIT cycle, empty wins
        bus.pkt_valid = 1'b1;
        step(); st("t3b_wait", O_WAIT);
        for (int i = 2; i <= 8; i++) step();
        bus.fifo_empty = 3'b111;
        step(); st("t3b_lfd", O_LFD);
        check("t3b_no_err", 32'(bus.timeout_err), 0);
        bus.pkt_valid = 1'b0;
        step(); st("t3b_ld", O_LD);
        step(); st("t3b_lp", O_LP);
        step(); st("t3b_cpe", O_CPE);
        step(); st("t3b_dec", O_DEC);

        // 4: full on 2nd LD cycle for 3 cycles
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd0;
        step(); st("t4_lfd", O_LFD);
        step(); st("t4_ld1", O_LD);
        step(); st("t4_ld2", O_LD);
        bus.fifo_full = 1'b1;
        step(); st("t4_full1", O_FULL);
        step(); st("t4_full2", O_FULL);
        step(); st("t4_full3", O_FULL);
        bus.fifo_full = 1'b0;
        step(); st("t4_laf", O_LAF);
        step(); st("t4_ld", O_LD);

        // LAF priority: low_packet_valid -> LP
        bus.fifo_full = 1'b1;
        step(); st("t4b_full", O_FULL);
        bus.fifo_full = 1'b0;
        step(); st("t4b_laf", O_LAF);
        bus.low_packet_valid = 1'b1;
        step(); st("t4b_lp", O_LP);
        bus.low_packet_valid = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.fifo_full = 1'b1;
        step(); st("t4b_cpe", O_CPE);
        step(); st("t4b_cpe_full", O_FULL);
        bus.fifo_full = 1'b0;
        step(); st("t4c_laf", O_LAF);
        bus.parity_done = 1'b1;
        bus.low_packet_valid = 1'b1;
        step(); st("t4c_dec", O_DEC);
        bus.parity_done = 1'b0;
        bus.low_packet_valid = 1'b0;

        // 5: soft reset on other channel ignored, selected one aborts
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd0;
        step(); st("t5_lfd", O_LFD);
        step(); st("t5_ld", O_LD);
        bus.soft_reset = 3'b010;
        step(); st("t5_ignore", O_LD);
        bus.soft_reset = 3'b001;
        step(); st("t5_abort", O_DEC);
        bus.soft_reset = 3'b000;
        bus.pkt_valid = 1'b0;
        step(); st("t5_idle", O_DEC);

        // 6: async reset mid-LD
        bus.pkt_valid = 1'b1;
        bus.data_in = 2'd1;
        step(); st("t6_lfd", O_LFD);
        step(); st("t6_ld", O_LD);
        #2;
        reset = 1'b1;
        #1;
        st("t6_async", O_DEC);
        check("t6_dest", 32'(bus.dest_sel), 0);
        bus.pkt_valid = 1'b0;
        step();
        reset = 1'b0;
        step(); st("t6_idle", O_DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
